sparc_exu_ecl_div_seq: RTL and testbench



---
 rtl/sparc_exu_ecl_div_seq.sv | 127 ++++++++++++
 tb/tb_sparc_exu_ecl_div_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_exu_ecl_div_seq.sv
// sparc_exu_ecl_div_seq
//   Sequencer for the EXU iterative divider. After a request is accepted it
//   walks the datapath through operand load, NITER iteration cycles, an
//   optional sign-fixup cycle and a one-cycle completion pulse.
//
// Ports
//   clk, reset      core clock, synchronous active-high reset
//   se              scan enable (no functional effect)
//   div_req         divide request (level); div_req_signed, dividend_neg and
//                   divisor_neg qualify it
//   div_kill        abort the running or requesting operation
//   div_ack         request accepted this cycle (combinational)
//   div_busy        sequencer not idle
//   div_load        operand load enable
//   div_iter        iteration enable, div_cnt = iteration index
//   div_fix         sign-fixup enable
//   div_res_neg     latched "quotient negative" flag
//   div_done        result-valid pulse
module sparc_exu_ecl_div_seq #(
    parameter int unsigned NITER = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       se,
    input  logic       div_req,
    input  logic       div_req_signed,
    input  logic       dividend_neg,
    input  logic       divisor_neg,
    input  logic       div_kill,
    output logic       div_ack,
    output logic       div_busy,
    output logic       div_load,
    output logic       div_iter,
    output logic [5:0] div_cnt,
    output logic       div_fix,
    output logic       div_res_neg,
    output logic       div_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(NITER - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       res_neg_q, res_neg_d;
    logic       signed_q, signed_d;

    logic unused_se;
    assign unused_se = se;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        res_neg_d = res_neg_q;
        signed_d  = signed_q;
        div_ack   = 1'b0;
        div_load  = 1'b0;
        div_iter  = 1'b0;
        div_fix   = 1'b0;
        div_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Reset is folded in so a request in a reset cycle is never acked.
                div_ack = div_req & ~div_kill & ~reset;
                if (div_ack) begin
                    state_d   = S_LOAD;
                    signed_d  = div_req_signed;
                    res_neg_d = div_req_signed & (dividend_neg ^ divisor_neg);
                end
            end
            S_LOAD: begin
                div_load = 1'b1;
                state_d  = S_ITER;
            end
            S_ITER: begin
                div_iter = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = (signed_q & res_neg_q) ? S_FIX : S_DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_FIX: begin
                div_fix = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                div_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Kill only redirects the next state; this cycle's enables stand.
        if (state_q != S_IDLE && div_kill) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            signed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            signed_q  <= signed_d;
        end
    end

    assign div_busy    = (state_q != S_IDLE);
    assign div_cnt     = cnt_q;
    assign div_res_neg = res_neg_q;

endmodule

// File: tb/tb_sparc_exu_ecl_div_seq.sv
// tb_sparc_exu_ecl_div_seq
//   Self-checking bench for the divider sequencer. Two instances (NITER=64
//   and NITER=4) share the stimulus; one is selected for checking at a time.
//   A schedule-queue reference model predicts every output every cycle.
module tb_sparc_exu_ecl_div_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       se = 1'b0;
    logic       div_req = 1'b0, div_req_signed = 1'b0;
    logic       dividend_neg = 1'b0, divisor_neg = 1'b0, div_kill = 1'b0;

    logic       d0_ack, d0_busy, d0_load, d0_iter, d0_fix, d0_res_neg, d0_done;
    logic [5:0] d0_cnt;
    logic       d1_ack, d1_busy, d1_load, d1_iter, d1_fix, d1_res_neg, d1_done;
    logic [5:0] d1_cnt;

    always #5 clk = ~clk;

    sparc_exu_ecl_div_seq #(.NITER(64)) dut (
        .clk(clk), .reset(reset), .se(se), .div_req(div_req),
        .div_req_signed(div_req_signed), .dividend_neg(dividend_neg),
        .divisor_neg(divisor_neg), .div_kill(div_kill),
        .div_ack(d0_ack), .div_busy(d0_busy), .div_load(d0_load),
        .div_iter(d0_iter), .div_cnt(d0_cnt), .div_fix(d0_fix),
        .div_res_neg(d0_res_neg), .div_done(d0_done)
    );

    sparc_exu_ecl_div_seq #(.NITER(4)) dut4 (
        .clk(clk), .reset(reset), .se(se), .div_req(div_req),
        .div_req_signed(div_req_signed), .dividend_neg(dividend_neg),
        .divisor_neg(divisor_neg), .div_kill(div_kill),
        .div_ack(d1_ack), .div_busy(d1_busy), .div_load(d1_load),
        .div_iter(d1_iter), .div_cnt(d1_cnt), .div_fix(d1_fix),
        .div_res_neg(d1_res_neg), .div_done(d1_done)
    );

    bit         sel = 1'b0;
    logic       o_ack, o_busy, o_load, o_iter, o_fix, o_res_neg, o_done;
    logic [5:0] o_cnt;

    always_comb begin
        o_ack     = sel ? d1_ack     : d0_ack;
        o_busy    = sel ? d1_busy    : d0_busy;
        o_load    = sel ? d1_load    : d0_load;
        o_iter    = sel ? d1_iter    : d0_iter;
        o_fix     = sel ? d1_fix     : d0_fix;
        o_res_neg = sel ? d1_res_neg : d0_res_neg;
        o_done    = sel ? d1_done    : d0_done;
        o_cnt     = sel ? d1_cnt     : d0_cnt;
    end

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: an accepted divide becomes a queue of per-cycle phases.
    typedef struct packed {
        logic       load;
        logic       iter;
        logic       fix;
        logic       done;
        logic [5:0] cnt;
    } ph_t;

    ph_t         sched[$];
    bit          m_res_neg = 1'b0;
    int unsigned niter = 64;

    // Outputs sampled in the most recent cycle.
    logic s_ack, s_busy, s_fix, s_done, s_res_neg;

    task automatic cycle(input logic req, input logic sg, input logic dn,
                         input logic vn, input logic kill, input logic rst);
        ph_t         e;
        logic        e_ack, e_busy;
        logic [12:0] act, exp;
        div_req = req; div_req_signed = sg; dividend_neg = dn;
        divisor_neg = vn; div_kill = kill; reset = rst;
        @(negedge clk);
        if (sched.size() == 0) begin
            e = '0; e_busy = 1'b0; e_ack = req & ~kill & ~rst;
        end else begin
            e = sched[0]; e_busy = 1'b1; e_ack = 1'b0;
        end
        s_ack = o_ack; s_busy = o_busy; s_fix = o_fix; s_done = o_done;
        s_res_neg = o_res_neg;
        act = {o_ack, o_busy, o_load, o_iter, o_fix, o_done, o_res_neg, o_cnt};
        exp = {e_ack, e_busy, e.load, e.iter, e.fix, e.done, m_res_neg, e.cnt};
        check("cycle{ack,busy,load,iter,fix,done,res_neg,cnt}", 32'(act), 32'(exp));
        if (rst) begin
            sched.delete();
            m_res_neg = 1'b0;
        end else if (e_busy) begin
            void'(sched.pop_front());
            if (kill) sched.delete();
        end else if (e_ack) begin
            m_res_neg = sg & (dn ^ vn);
            sched.push_back(ph_t'{1'b1, 1'b0, 1'b0, 1'b0, 6'd0});
            for (int unsigned i = 0; i < niter; i++)
                sched.push_back(ph_t'{1'b0, 1'b1, 1'b0, 1'b0, 6'(i)});
            if (m_res_neg) sched.push_back(ph_t'{1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
            sched.push_back(ph_t'{1'b0, 1'b0, 1'b0, 1'b1, 6'd0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset without checking (used when switching instance or at power-up).
    task automatic hard_reset();
        reset = 1'b1; div_req = 1'b0; div_kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sched.delete();
        m_res_neg = 1'b0;
    endtask

    task automatic wait_done(output int done_at, output bit fix_seen);
        done_at = 0; fix_seen = 1'b0;
        for (int k = 1; k <= 80 && done_at == 0; k++) begin
            idle();
            if (s_fix)  fix_seen = 1'b1;
            if (s_done) done_at = k;
        end
    endtask

    typedef struct {
        logic req, sg, dn, vn, kill;
        logic ack, res_neg, fix;
        int   done_at;
    } vec_t;

    vec_t vt64[$];
    vec_t vt4[$];

    task automatic run_entry(input vec_t v);
        int done_at;
        bit fix_seen;
        cycle(v.req, v.sg, v.dn, v.vn, v.kill, 1'b0);
        check("tbl_ack", 32'(s_ack), 32'(v.ack));
        wait_done(done_at, fix_seen);
        check("tbl_done_at", 32'(done_at), 32'(v.done_at));
        check("tbl_fix", 32'(fix_seen), 32'(v.fix));
        if (v.ack) check("tbl_res_neg", 32'(s_res_neg), 32'(v.res_neg));
    endtask

    initial begin
        int  done_at;
        bit  fix_seen;
        int  acks;
        int  ack_t[$];

        //                 req sg dn vn kill  ack rneg fix done_at
        vt64.push_back('{1, 0, 1, 0, 0,   1, 0, 0, 66});
        vt64.push_back('{1, 1, 1, 0, 0,   1, 1, 1, 67});
        vt64.push_back('{1, 1, 1, 1, 0,   1, 0, 0, 66});
        vt64.push_back('{1, 1, 0, 1, 0,   1, 1, 1, 67});
        vt64.push_back('{1, 0, 0, 1, 0,   1, 0, 0, 66});
        vt64.push_back('{1, 1, 0, 1, 1,   0, 0, 0, 0});
        vt64.push_back('{0, 1, 1, 0, 0,   0, 0, 0, 0});
        vt4.push_back('{1, 0, 1, 1, 0,   1, 0, 0, 6});
        vt4.push_back('{1, 1, 1, 0, 0,   1, 1, 1, 7});
        vt4.push_back('{1, 1, 0, 0, 0,   1, 0, 0, 6});

        hard_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_ack", 32'(s_ack), 32'd0);
        check("reset_busy", 32'(s_busy), 32'd0);

        foreach (vt64[i]) run_entry(vt64[i]);

        // Kill at iteration 10, then a fresh request two cycles later.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && o_cnt != 6'd10; k++) idle();
        check("kill_cnt_reached", 32'(o_cnt), 32'd10);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        check("kill_busy", 32'(s_busy), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("kill_reack", 32'(s_ack), 32'd1);
        wait_done(done_at, fix_seen);
        check("kill_redone_at", 32'(done_at), 32'd66);

        // Request held high: acks only in idle cycles, 67 cycles apart.
        acks = 0;
        for (int k = 0; k < 140; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (s_ack) begin acks++; ack_t.push_back(k); end
        end
        check("held_ack_count", 32'(acks), 32'd3);
        if (ack_t.size() >= 2) check("held_ack_gap", 32'(ack_t[1] - ack_t[0]), 32'd67);
        for (int k = 0; k < 80 && o_busy; k++) idle();
        check("held_drained", 32'(o_busy), 32'd0);

        // Kill in DONE keeps that cycle's done pulse.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 80 && !o_done; k++) idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("kill_in_done", 32'(s_done), 32'd1);
        idle();
        check("after_done_busy", 32'(s_busy), 32'd0);

        // Reset during ITER.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        check("rst_iter_busy", 32'(s_busy), 32'd0);
        check("rst_iter_res_neg", 32'(s_res_neg), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++)
            cycle($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 63) == 0, $urandom_range(0, 999) == 0);

        // NITER = 4 instance.
        sel = 1'b1;
        niter = 4;
        hard_reset();
        foreach (vt4[i]) run_entry(vt4[i]);
        for (int k = 0; k < 1000; k++)
            cycle($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
